// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package dmem_arb_pkg;
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_MEM  = 2'd2
    } own_e;

    localparam logic [3:0] WE_LOAD = 4'b0000;
endpackage

// File: rtl/dmem_arbiter_if.sv
// Pipeline-side and RAM-side signals of the arbiter; slave is the arbiter view.
interface dmem_arbiter_if #(
    parameter int ADDR_W = dmem_arb_pkg::ADDR_W_DEF,
    parameter int DATA_W = dmem_arb_pkg::DATA_W_DEF
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    logic              stall_if;

    logic                mem_req;
    logic [DATA_W/8-1:0] mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_rdata;
    logic                mem_valid;
    logic                stall_mem;

    logic                ram_en;
    logic [DATA_W/8-1:0] ram_we;
    logic [ADDR_W-1:0]   ram_addr;
    logic [DATA_W-1:0]   ram_wdata;
    logic [DATA_W-1:0]   ram_rdata;

    modport slave (
        input  if_req, if_addr, if_flush, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
        output if_rdata, if_valid, stall_if, mem_rdata, mem_valid, stall_mem,
               ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output if_req, if_addr, if_flush, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
        input  if_rdata, if_valid, stall_if, mem_rdata, mem_valid, stall_mem,
               ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/dmem_arbiter_starve_ctr.sv
// Counts consecutive IF losses; force_if lets IF win once the limit is reached.
module arb_starve_ctr #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic inc,
    output logic force_if
);
    localparam logic [3:0] LIM = 4'(LIMIT);

    logic [3:0] cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                cnt <= 4'd0;
        else if (clear)             cnt <= 4'd0;
        else if (inc && cnt != LIM) cnt <= cnt + 4'd1;
    end

    assign force_if = (cnt == LIM);
endmodule

// File: rtl/dmem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and the MEM stage.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            resetn,
    dmem_arbiter_if.slave   bus
);
    logic              if_grant, mem_grant, force_if;
    logic              flush_seen;
    own_e              resp_own, own_nxt;
    logic [DATA_W-1:0] if_hold, mem_hold;

    // MEM has priority; a starved IF takes one cycle when the counter saturates.
    always_comb begin
        if_grant  = bus.if_req & (~bus.mem_req | force_if);
        mem_grant = bus.mem_req & ~if_grant;
        own_nxt   = if_grant ? OWN_IF : (mem_grant ? OWN_MEM : OWN_NONE);
    end

    assign bus.stall_if  = bus.if_req & ~if_grant;
    assign bus.stall_mem = bus.mem_req & ~mem_grant;

    always_comb begin
        bus.ram_en    = if_grant | mem_grant;
        bus.ram_addr  = if_grant ? bus.if_addr : bus.mem_addr;
        bus.ram_wdata = bus.mem_wdata;
        bus.ram_we    = (mem_grant & resetn) ? bus.mem_we : WE_LOAD;
    end

    arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk      (clk),
        .resetn   (resetn),
        .clear    (if_grant | ~bus.if_req),
        .inc      (bus.if_req & mem_grant),
        .force_if (force_if)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            resp_own   <= OWN_NONE;
            flush_seen <= 1'b0;
            if_hold    <= '0;
            mem_hold   <= '0;
        end else begin
            resp_own   <= own_nxt;
            flush_seen <= if_grant & bus.if_flush;
            if (bus.if_valid)  if_hold  <= bus.ram_rdata;
            if (bus.mem_valid) mem_hold <= bus.ram_rdata;
        end
    end

    // A flush either in the grant cycle or in the response cycle drops the fetch.
    assign bus.if_valid  = (resp_own == OWN_IF) & ~flush_seen & ~bus.if_flush;
    assign bus.mem_valid = (resp_own == OWN_MEM);
    assign bus.if_rdata  = bus.if_valid  ? bus.ram_rdata : if_hold;
    assign bus.mem_rdata = bus.mem_valid ? bus.ram_rdata : mem_hold;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural RAM and response scoreboard.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    typedef struct packed {
        logic        chk;
        logic [31:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if bus ();

    dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    logic [31:0] ram     [256];
    logic [31:0] ref_mem [256];
    exp_t        if_q [$];
    exp_t        mem_q [$];
    int          checks = 0;
    int          errors = 0;

    int          prev_g = 0;
    bit          prev_fl = 0;
    exp_t        prev_e;
    logic [31:0] last_if = '0;

    function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n, logic [3:0] we);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (we[b]) r[b*8 +: 8] = n[b*8 +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (bus.ram_en) begin
            ram[bus.ram_addr] <= merge(ram[bus.ram_addr], bus.ram_wdata, bus.ram_we);
            bus.ram_rdata     <= merge(ram[bus.ram_addr], bus.ram_wdata, bus.ram_we);
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever a valid pulse is presented.
    always @(negedge clk) begin
        exp_t e;
        if (!resetn) begin
            last_if = '0;
            check("mem_rdata_rst", bus.mem_rdata, 32'h0);
        end
        if (bus.if_valid) begin
            if (if_q.size() == 0) check("if_valid_unexpected", 32'd1, 32'd0);
            else begin
                e = if_q.pop_front();
                check("if_rdata", bus.if_rdata, e.d);
                last_if = e.d;
            end
        end else begin
            check("if_rdata_hold", bus.if_rdata, last_if);
        end
        if (bus.mem_valid) begin
            if (mem_q.size() == 0) check("mem_valid_unexpected", 32'd1, 32'd0);
            else begin
                e = mem_q.pop_front();
                if (e.chk) check("mem_rdata", bus.mem_rdata, e.d);
                else check("mem_valid_store", 32'd1, 32'd1 & {31'd0, bus.mem_valid});
            end
        end
        if (if_q.size() != 0) begin
            check("if_valid_missing", 32'd0, 32'd1);
            if_q.delete();
        end
        if (mem_q.size() != 0) begin
            check("mem_valid_missing", 32'd0, 32'd1);
            mem_q.delete();
        end
    end

    // One cycle of stimulus; eg is the hand-expected grant (0 none, 1 IF, 2 MEM).
    task automatic cyc(input bit ir, input logic [7:0] ia, input bit fl, input bit mr,
                       input logic [3:0] mwe, input logic [7:0] ma, input logic [31:0] md,
                       input int eg, input string nm);
        logic [3:0] exp_we;
        bus.if_req = ir; bus.if_addr = ia; bus.if_flush = fl;
        bus.mem_req = mr; bus.mem_we = mwe; bus.mem_addr = ma; bus.mem_wdata = md;
        if (prev_g == 1 && !prev_fl && !fl) if_q.push_back(prev_e);
        if (prev_g == 2) mem_q.push_back(prev_e);
        #1;
        exp_we = (eg == 2 && resetn) ? mwe : 4'h0;
        check({nm, ".ram_en"}, {31'd0, bus.ram_en}, {31'd0, eg != 0});
        check({nm, ".ram_we"}, {28'd0, bus.ram_we}, {28'd0, exp_we});
        check({nm, ".stall_if"}, {31'd0, bus.stall_if}, {31'd0, ir && eg != 1});
        check({nm, ".stall_mem"}, {31'd0, bus.stall_mem}, {31'd0, mr && eg != 2});
        if (eg != 0) check({nm, ".ram_addr"}, {24'd0, bus.ram_addr}, {24'd0, eg == 1 ? ia : ma});
        prev_fl = fl;
        if (eg == 1) prev_e = '{chk: 1'b1, d: ref_mem[ia]};
        if (eg == 2) begin
            prev_e = '{chk: (mwe == 4'h0), d: ref_mem[ma]};
            if (resetn && mwe != 4'h0) ref_mem[ma] = merge(ref_mem[ma], md, mwe);
        end
        prev_g = resetn ? eg : 0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 8'h00, 0, 0, 4'h0, 8'h00, 32'h0, 0, "idle");
    endtask

    task automatic both(input int eg, input logic [7:0] ia);
        cyc(1, ia, 0, 1, 4'h0, 8'h20, 32'h0, eg, "both");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]     = 32'(i) * 32'h01010101;
            ref_mem[i] = 32'(i) * 32'h01010101;
        end
        ram[8'h10] = 32'hDEADBEEF; ref_mem[8'h10] = 32'hDEADBEEF;
        ram[8'h20] = 32'h12345678; ref_mem[8'h20] = 32'h12345678;
        ram[8'h05] = 32'hA5A5A5A5; ref_mem[8'h05] = 32'hA5A5A5A5;
        bus.ram_rdata = '0;
        bus.if_req = 0; bus.if_addr = '0; bus.if_flush = 0;
        bus.mem_req = 0; bus.mem_we = '0; bus.mem_addr = '0; bus.mem_wdata = '0;

        // Reset with both requesting; a write strobe must not reach the RAM.
        repeat (2) @(posedge clk);
        #1;
        cyc(1, 8'h10, 0, 1, 4'hF, 8'h30, 32'hFFFFFFFF, 2, "rst");
        cyc(1, 8'h10, 0, 1, 4'hF, 8'h30, 32'hFFFFFFFF, 2, "rst");
        resetn = 1'b1;

        // Continuous contention from a cleared counter.
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) both(2, 8'h10);
            both(1, 8'h11);
        end
        idle(1);

        // IF only.
        cyc(1, 8'h10, 0, 0, 4'h0, 8'h00, 32'h0, 1, "if_only");
        idle(1);

        // Store then read-after-write load.
        cyc(0, 8'h00, 0, 1, 4'b0011, 8'h05, 32'h0000BEEF, 2, "store");
        cyc(0, 8'h00, 0, 1, 4'h0, 8'h05, 32'h0, 2, "load");
        idle(1);
        check("raw_value", ref_mem[8'h05], 32'hA5A5BEEF);

        // Flush in the response cycle, with a MEM grant alongside.
        cyc(1, 8'h10, 0, 0, 4'h0, 8'h00, 32'h0, 1, "fl_grant");
        cyc(0, 8'h00, 1, 1, 4'h0, 8'h20, 32'h0, 2, "fl_resp");
        idle(1);

        // Flush in the grant cycle; the following fetch is unaffected.
        cyc(1, 8'h11, 1, 0, 4'h0, 8'h00, 32'h0, 1, "fl_early");
        cyc(1, 8'h10, 0, 0, 4'h0, 8'h00, 32'h0, 1, "fl_after");
        idle(1);

        // if_req dropping clears the loss count.
        both(2, 8'h10); both(2, 8'h10);
        cyc(0, 8'h00, 0, 1, 4'h0, 8'h20, 32'h0, 2, "mem_only");
        for (int k = 0; k < 4; k++) both(2, 8'h10);
        both(1, 8'h10);

        // At the limit, a lone MEM request still wins and the count clears.
        for (int k = 0; k < 4; k++) both(2, 8'h10);
        cyc(0, 8'h00, 0, 1, 4'h0, 8'h20, 32'h0, 2, "lim_mem");
        both(2, 8'h11);
        idle(1);

        // Async reset while a MEM response is on the bus.
        cyc(0, 8'h00, 0, 1, 4'h0, 8'h20, 32'h0, 2, "pre_rst");
        bus.mem_req = 0;
        #1;
        check("mem_valid_pre_rst", {31'd0, bus.mem_valid}, 32'd1);
        prev_g = 0;
        resetn = 1'b0;
        #1;
        check("mem_valid_in_rst", {31'd0, bus.mem_valid}, 32'd0);
        check("mem_rdata_in_rst", bus.mem_rdata, 32'h0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
